// File: rtl/sonar_varredura.sv
// Sonar sweep controller: steps the servo, triggers HC-SR04 measurements and
// streams one 7-byte ASCII frame per position ("Pp,ddd#") over the serial TX.
module sonar_varredura #(
    parameter int unsigned N_POS   = 8,
    parameter int unsigned POS_W   = 4,
    parameter int unsigned SETTLE  = 50000000,
    parameter int unsigned TIMEOUT = 1500000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             modo,
    output logic             medir,
    input  logic             fim_medicao,
    input  logic [11:0]      medida,
    output logic [POS_W-1:0] posicao,
    output logic             tx_partida,
    output logic [7:0]       tx_dado,
    input  logic             tx_pronto,
    output logic             fim_posicao,
    output logic             erro_timeout,
    output logic [3:0]       db_estado
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned K_W   = 3;

    localparam logic [3:0] INICIAL    = 4'd0;
    localparam logic [3:0] ESPERA     = 4'd1;
    localparam logic [3:0] MEDE       = 4'd2;
    localparam logic [3:0] AGUARDA    = 4'd3;
    localparam logic [3:0] PREPARA    = 4'd4;
    localparam logic [3:0] TRANSMITE  = 4'd5;
    localparam logic [3:0] AGUARDA_TX = 4'd6;
    localparam logic [3:0] ATUALIZA   = 4'd7;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 2);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(6);

    logic [3:0]       state, state_nxt;
    logic [SET_W-1:0] settle_cnt, settle_nxt;
    logic [TO_W-1:0]  tout_cnt, tout_nxt;
    logic [K_W-1:0]   k, k_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             dir_up, dir_nxt;
    logic             erro_nxt;
    logic [11:0]      med_q, med_nxt;
    logic [7:0]       tx_dado_nxt;
    logic             medir_nxt, partida_nxt, fim_pos_nxt;

    // Byte idx of the frame for the given position/measurement.
    function automatic logic [7:0] frame_byte(input logic [K_W-1:0] idx,
                                              input logic [3:0]     pos,
                                              input logic [11:0]    med,
                                              input logic           err);
        logic [7:0] b;
        logic [3:0] dig;
        b   = 8'h23;
        dig = 4'd0;
        case (idx)
            3'd0: b = 8'h50;
            3'd1: b = (pos < 4'd10) ? 8'h30 + {4'd0, pos} : 8'h37 + {4'd0, pos};
            3'd2: b = 8'h2C;
            3'd3, 3'd4, 3'd5: begin
                if (idx == 3'd3)      dig = med[11:8];
                else if (idx == 3'd4) dig = med[7:4];
                else                  dig = med[3:0];
                b = err ? 8'h2D : 8'h30 + {4'd0, dig};
            end
            default: b = 8'h23;
        endcase
        return b;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= INICIAL;
            settle_cnt   <= '0;
            tout_cnt     <= '0;
            k            <= '0;
            posicao      <= '0;
            dir_up       <= 1'b1;
            erro_timeout <= 1'b0;
            med_q        <= '0;
            tx_dado      <= '0;
            medir        <= 1'b0;
            tx_partida   <= 1'b0;
            fim_posicao  <= 1'b0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_nxt;
            tout_cnt     <= tout_nxt;
            k            <= k_nxt;
            posicao      <= pos_nxt;
            dir_up       <= dir_nxt;
            erro_timeout <= erro_nxt;
            med_q        <= med_nxt;
            tx_dado      <= tx_dado_nxt;
            medir        <= medir_nxt;
            tx_partida   <= partida_nxt;
            fim_posicao  <= fim_pos_nxt;
        end
    end

    assign db_estado = state;

    // Pulse outputs are registered from the state being entered, so each is
    // high exactly during its state's cycle.
    always_comb begin
        state_nxt   = state;
        settle_nxt  = settle_cnt;
        tout_nxt    = tout_cnt;
        k_nxt       = k;
        pos_nxt     = posicao;
        dir_nxt     = dir_up;
        erro_nxt    = erro_timeout;
        med_nxt     = med_q;
        tx_dado_nxt = tx_dado;
        medir_nxt   = 1'b0;
        partida_nxt = 1'b0;
        fim_pos_nxt = 1'b0;

        case (state)
            INICIAL: begin
                if (ligar) begin
                    state_nxt  = ESPERA;
                    settle_nxt = '0;
                end
            end
            ESPERA: begin
                if (settle_cnt == SET_LAST) begin
                    state_nxt = MEDE;
                    medir_nxt = 1'b1;
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            MEDE: begin
                tout_nxt  = '0;
                state_nxt = AGUARDA;
            end
            AGUARDA: begin
                // The medir cycle counts toward the allowed window.
                if (fim_medicao) begin
                    med_nxt   = medida;
                    erro_nxt  = 1'b0;
                    state_nxt = PREPARA;
                end else if (tout_cnt == TO_LAST) begin
                    erro_nxt  = 1'b1;
                    state_nxt = PREPARA;
                end else begin
                    tout_nxt = tout_cnt + TO_W'(1);
                end
            end
            PREPARA: begin
                k_nxt       = '0;
                state_nxt   = TRANSMITE;
                partida_nxt = 1'b1;
                tx_dado_nxt = frame_byte(K_W'(0), 4'(posicao), med_q, erro_timeout);
            end
            TRANSMITE: begin
                state_nxt = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                if (tx_pronto) begin
                    if (k == K_LAST) begin
                        state_nxt   = ATUALIZA;
                        fim_pos_nxt = 1'b1;
                    end else begin
                        k_nxt       = k + K_W'(1);
                        state_nxt   = TRANSMITE;
                        partida_nxt = 1'b1;
                        tx_dado_nxt = frame_byte(k + K_W'(1), 4'(posicao), med_q, erro_timeout);
                    end
                end
            end
            ATUALIZA: begin
                if (!modo) begin
                    pos_nxt = (posicao == POS_LAST) ? '0 : posicao + POS_W'(1);
                end else if (posicao == POS_LAST) begin
                    pos_nxt = posicao - POS_W'(1);
                    dir_nxt = 1'b0;
                end else if (posicao == '0) begin
                    pos_nxt = posicao + POS_W'(1);
                    dir_nxt = 1'b1;
                end else begin
                    pos_nxt = dir_up ? posicao + POS_W'(1) : posicao - POS_W'(1);
                end
                settle_nxt = '0;
                state_nxt  = ligar ? ESPERA : INICIAL;
            end
            default: state_nxt = INICIAL;
        endcase
    end

endmodule
